rref_matrix_loader: RTL and testbench

Upstream feeder for the 5x5 Gauss-Jordan `RREF` stage. It accepts a 5x5 matrix of 32-bit integers as a row-major word stream over a valid/ready handshake and assembles it into the flat `a` bus. It drives the `b` bus with the 5x5 identity. Once all 25 words are captured, it presents both buses stably to `RREF` and holds them under an output valid/ready handshake until the consumer takes the matrix. Framing errors are detected, and the partial matrix is discarded.

---
 rtl/rref_matrix_loader_pkg.sv | 34 +++
 rtl/rref_matrix_loader_if.sv | 28 ++
 rtl/rref_word_counter.sv | 35 +++
 rtl/rref_matrix_loader.sv | 115 +++++++++++
 tb/tb_rref_matrix_loader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rref_matrix_loader_pkg.sv
// Shared definitions for the RREF matrix loader: matrix geometry, element
// indexing, the constant identity matrix and the loader state encoding.
package rref_pkg;

    localparam int N      = 5;
    localparam int W      = 32;
    localparam int NN     = N * N;
    localparam int FLAT_W = N * N * W;
    localparam int CNT_W  = 5;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    // Flat element index of (row, column) in row-major order.
    function automatic int idx(input int r, input int c);
        return N * r + c;
    endfunction

    // Identity matrix packed the same way as a_flat: a 1 in the LSB of each
    // diagonal element, every other bit 0.
    function automatic logic [FLAT_W-1:0] build_identity();
        logic [FLAT_W-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++) begin
            m[W * idx(r, r)] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [FLAT_W-1:0] IDENTITY_FLAT = build_identity();

endpackage

// File: rtl/rref_matrix_loader_if.sv
// Word-stream input, matrix output and status signals of the loader.
// The slave side is the loader itself; the master side is whoever feeds
// words in and consumes the assembled matrix.
interface rref_matrix_loader_if;
    import rref_pkg::*;

    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [FLAT_W-1:0] a_flat;
    logic [FLAT_W-1:0] b_flat;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  word_cnt;
    logic              frame_err;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, a_flat, b_flat, out_valid, word_cnt, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, a_flat, b_flat, out_valid, word_cnt, frame_err
    );

endinterface

// File: rtl/rref_word_counter.sv
// Counts accepted words of the current frame (0..25). Clear wins over
// increment, and the count never runs past a full frame.
module rref_word_counter
    import rref_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             is_24,
    output logic             is_25
);

    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(NN - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NN);

    logic [CNT_W-1:0] count_q;

    // Word count register: reset/clear to zero, otherwise step on each stored word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != FULL_COUNT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;
    assign is_24 = (count_q == LAST_SLOT);
    assign is_25 = (count_q == FULL_COUNT);

endmodule

// File: rtl/rref_matrix_loader.sv
// Assembles a row-major 25-word stream into the flat 5x5 'a' bus for the
// combinational RREF stage, supplies the identity as the 'b' bus, and holds
// the complete matrix until the consumer takes it. A frame whose last marker
// does not line up with word 25 is discarded and flagged.
module rref_matrix_loader
    import rref_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    rref_matrix_loader_if.slave bus
);

    state_t            state_q;
    state_t            state_d;
    logic [FLAT_W-1:0] a_q;
    logic              frame_err_q;

    logic              accept;
    logic              frame_bad;
    logic              store;
    logic              take;
    logic [NN-1:0]     slot_we;

    logic [CNT_W-1:0]  word_cnt;
    logic              is_24;
    logic              is_25;

    rref_word_counter u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (store),
        .clr   (frame_bad | take),
        .count (word_cnt),
        .is_24 (is_24),
        .is_25 (is_25)
    );

    // Next state plus the accept / framing-error / handshake strobes.
    // A word only counts as good when the last marker coincides with slot 24;
    // a marker anywhere else, or its absence on slot 24, spoils the frame.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        frame_bad = 1'b0;
        take      = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (bus.in_last && is_24) begin
                        state_d = FULL;
                    end else if (bus.in_last || is_24) begin
                        frame_bad = 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.out_ready && is_25) begin
                    take    = 1'b1;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign store = accept & ~frame_bad;

    // One-hot slot write enables decoded from the current word count.
    always_comb begin
        slot_we = '0;
        for (int i = 0; i < NN; i++) begin
            if (store && (word_cnt == CNT_W'(i))) begin
                slot_we[i] = 1'b1;
            end
        end
    end

    // Matrix register: cleared when a frame is discarded or handed off,
    // otherwise each stored word lands in its own slot bit-exact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
        end else if (frame_bad || take) begin
            a_q <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (slot_we[i]) begin
                    a_q[i*W +: W] <= bus.in_data;
                end
            end
        end
    end

    // State register and the registered one-cycle framing error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= frame_bad;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == FULL);
    assign bus.word_cnt  = word_cnt;
    assign bus.frame_err = frame_err_q;
    assign bus.a_flat    = a_q;
    assign bus.b_flat    = IDENTITY_FLAT;

endmodule

// File: tb/tb_rref_matrix_loader.sv
// Randomized self-checking bench for rref_matrix_loader. A frame-level model
// (an array of 25 words, a word count and a full flag) predicts every output
// after each clock edge.
module tb_rref_matrix_loader;
    import rref_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rref_matrix_loader_if bus();

    rref_matrix_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0]      m_a [25];
    bit                m_full;
    bit                m_err;
    int                m_cnt;
    logic [FLAT_W-1:0] exp_identity;
    logic [W-1:0]      frame [25];
    logic [FLAT_W-1:0] snapshot;

    task automatic checkOutput(input string tag, input logic [FLAT_W-1:0] got,
                               input logic [FLAT_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FLAT_W-1:0] packModel();
        logic [FLAT_W-1:0] p;
        p = '0;
        for (int k = 0; k < 25; k++) p[k*32 +: 32] = m_a[k];
        return p;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 25; k++) m_a[k] = '0;
        m_cnt = 0;
    endtask

    // Frame-level behaviour for one clock edge with the given inputs.
    task automatic modelEdge(input bit rst_v, input bit v, input bit last,
                             input logic [W-1:0] d, input bit ordy);
        m_err = 0;
        if (rst_v) begin
            modelClear();
            m_full = 0;
        end else if (!m_full) begin
            if (v) begin
                if (last && m_cnt == 24) begin
                    m_a[24] = d;
                    m_cnt   = 25;
                    m_full  = 1;
                end else if (last || m_cnt == 24) begin
                    modelClear();
                    m_err = 1;
                end else begin
                    m_a[m_cnt] = d;
                    m_cnt++;
                end
            end
        end else if (ordy) begin
            modelClear();
            m_full = 0;
        end
    endtask

    task automatic checkAll();
        checkOutput("in_ready",  FLAT_W'(bus.in_ready),  FLAT_W'(!m_full));
        checkOutput("out_valid", FLAT_W'(bus.out_valid), FLAT_W'(m_full));
        checkOutput("word_cnt",  FLAT_W'(bus.word_cnt),  FLAT_W'(m_cnt));
        checkOutput("frame_err", FLAT_W'(bus.frame_err), FLAT_W'(m_err));
        checkOutput("a_flat",    bus.a_flat,             packModel());
        checkOutput("b_flat",    bus.b_flat,             exp_identity);
    endtask

    // Drive one cycle of inputs, step the model on the edge, check at negedge.
    task automatic applyStimulus(input bit rst_v, input bit v, input bit last,
                                 input logic [W-1:0] d, input bit ordy);
        rst_n         = !rst_v;
        bus.in_valid  = v;
        bus.in_last   = last;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        modelEdge(rst_v, v, last, d, ordy);
        @(negedge clk);
        checkAll();
    endtask

    task automatic sendWord(input logic [W-1:0] d, input bit last, input bit ordy);
        applyStimulus(1'b0, 1'b1, last, d, ordy);
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(1'b0, 1'b0, 1'b0, $urandom, ordy);
    endtask

    initial begin
        int k;
        int guard;
        int prev_cnt;
        bit v;
        bit last;

        exp_identity = '0;
        for (int r = 0; r < 5; r++) exp_identity[(r * 5 + r) * 32] = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_full = 0;
        m_err  = 0;
        modelClear();

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hdead_beef, 1'b1);

        $display("[TB] sequential frame 1..25 with consumer ready");
        for (int i = 1; i <= 25; i++) sendWord(W'(i), i == 25, 1'b1);
        checkOutput("a00", FLAT_W'(bus.a_flat[31:0]), FLAT_W'(1));
        checkOutput("a12", FLAT_W'(bus.a_flat[(1*5+2)*32 +: 32]), FLAT_W'(8));
        checkOutput("a44", FLAT_W'(bus.a_flat[24*32 +: 32]), FLAT_W'(25));
        checkOutput("ov_after_25", FLAT_W'(bus.out_valid), FLAT_W'(1));
        idle(1'b1);
        checkOutput("ov_drop", FLAT_W'(bus.out_valid), FLAT_W'(0));

        $display("[TB] held matrix with consumer stalled");
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                sendWord(W'((c == 0 || r == 0) ? r + 1 : r + 2), (r == 4 && c == 4), 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'($urandom % 2), $urandom, 1'b0);
        idle(1'b1);
        checkOutput("ready_after_take", FLAT_W'(bus.in_ready), FLAT_W'(1));

        $display("[TB] early last on word 10");
        for (int i = 0; i < 9; i++) sendWord($urandom, 1'b0, 1'b0);
        sendWord($urandom, 1'b1, 1'b0);
        checkOutput("early_err", FLAT_W'(bus.frame_err), FLAT_W'(1));
        idle(1'b0);
        for (int i = 0; i < 25; i++) sendWord($urandom, i == 24, 1'b0);
        idle(1'b1);

        $display("[TB] missing last");
        for (int i = 0; i < 25; i++) sendWord($urandom, 1'b0, 1'b1);
        checkOutput("missing_err", FLAT_W'(bus.frame_err), FLAT_W'(1));
        checkOutput("missing_no_ov", FLAT_W'(bus.out_valid), FLAT_W'(0));
        idle(1'b1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 13; i++) sendWord($urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < 25; i++) sendWord($urandom, i == 24, 1'b1);
        idle(1'b1);

        $display("[TB] gapped load versus gap-free load");
        for (int i = 0; i < 25; i++) frame[i] = $urandom;
        for (int i = 0; i < 25; i++) sendWord(frame[i], i == 24, 1'b0);
        snapshot = packModel();
        idle(1'b1);
        k        = 0;
        guard    = 0;
        prev_cnt = 0;
        while (k < 25 && guard < 400) begin
            v = 1'($urandom % 2);
            applyStimulus(1'b0, v, v && (k == 24), v ? frame[k] : $urandom, 1'b0);
            if (v) k++;
            guard++;
            if (k < 25) begin
                checkOutput("cnt_monotonic", FLAT_W'(bus.word_cnt >= 5'(prev_cnt)), FLAT_W'(1));
                prev_cnt = int'(bus.word_cnt);
            end
        end
        checkOutput("gap_frame_done", FLAT_W'(k), FLAT_W'(25));
        checkOutput("gap_vs_nogap", bus.a_flat, snapshot);
        idle(1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            v    = 1'($urandom % 4 != 0);
            last = (m_cnt == 24) ? 1'($urandom % 16 != 0) : 1'($urandom % 40 == 0);
            applyStimulus(1'($urandom % 150 == 0), v, last, $urandom, 1'($urandom % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
